// File: rtl/mux_2_to_1_if.sv
// Signal bundle for the 2:1 datapath selector: data/select inputs from the
// producer side, combinational and registered observation outputs back.
interface mux_2_to_1_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             sel;
  logic             cnt_clr;
  logic [WIDTH-1:0] MuxOut;
  logic [WIDTH-1:0] MuxOutQ;
  logic             sel_q;
  logic [CNT_W-1:0] toggle_cnt;

  modport master (
    output A, B, sel, cnt_clr,
    input  MuxOut, MuxOutQ, sel_q, toggle_cnt
  );

  modport slave (
    input  A, B, sel, cnt_clr,
    output MuxOut, MuxOutQ, sel_q, toggle_cnt
  );
endinterface

// File: rtl/mux_2_to_1.sv
// 2:1 selector for PC/operand paths: same-cycle combinational output plus a
// registered copy and a saturating count of select transitions for debug.
module mux_2_to_1 #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  mux_2_to_1_if.slave  bus
);

  logic [WIDTH-1:0] mux_d;
  logic [WIDTH-1:0] mux_out_q;
  logic             sel_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Conditional operator keeps per-bit X only where A and B disagree.
  assign mux_d = bus.sel ? bus.B : bus.A;

  always_comb begin
    cnt_d = cnt_q;
    if (bus.cnt_clr)
      cnt_d = '0;
    else if ((bus.sel != sel_q) && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mux_out_q <= '0;
      sel_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      mux_out_q <= mux_d;
      sel_q     <= bus.sel;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.MuxOut     = mux_d;
  assign bus.MuxOutQ    = mux_out_q;
  assign bus.sel_q      = sel_q;
  assign bus.toggle_cnt = cnt_q;

endmodule

// File: tb/tb_mux_2_to_1.sv
// Directed bench: combinational vector table, then registered path, reset,
// toggle counting, clear priority and saturation on a narrow-counter instance.
module tb_mux_2_to_1;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  mux_2_to_1_if #(.WIDTH(16), .CNT_W(16)) bus  ();
  mux_2_to_1_if #(.WIDTH(16), .CNT_W(3))  bus3 ();

  mux_2_to_1 #(.WIDTH(16), .CNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
  mux_2_to_1 #(.WIDTH(16), .CNT_W(3))  dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_sel(input logic s);
    bus.sel  = s;
    bus3.sel = s;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    vecs[0] = '{16'hAAAA, 16'h5555, 1'b0, 16'hAAAA};
    vecs[1] = '{16'h0000, 16'h5555, 1'b0, 16'h0000};
    vecs[2] = '{16'h0000, 16'h5555, 1'b1, 16'h5555};
    vecs[3] = '{16'h0000, 16'hFFFF, 1'b1, 16'hFFFF};
    vecs[4] = '{16'hA5A5, 16'hFFFF, 1'b1, 16'hFFFF};
    vecs[5] = '{16'hA5A5, 16'hFFFF, 1'b0, 16'hA5A5};
    vecs[6] = '{16'h1234, 16'hABCD, 1'b0, 16'h1234};

    rst = 1'b1;
    bus.A = '0;  bus.B = '0;  bus.cnt_clr = 1'b0;
    bus3.A = 16'h0F0F; bus3.B = 16'hF0F0; bus3.cnt_clr = 1'b0;
    set_sel(1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_muxoutq", 64'(bus.MuxOutQ), 64'h0);
    chk("rst_sel_q",   64'(bus.sel_q), 64'h0);
    chk("rst_cnt",     64'(bus.toggle_cnt), 64'h0);

    // Combinational vectors, applied while still in reset.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      bus.A = vecs[i].a;
      bus.B = vecs[i].b;
      set_sel(vecs[i].s);
      #1;
      chk($sformatf("comb_vec%0d", i), 64'(bus.MuxOut), 64'(vecs[i].exp));
    end

    // Registered path: first edge out of reset with sel=1.
    @(negedge clk);
    rst = 1'b0;
    bus.A = 16'h1234; bus.B = 16'hABCD; set_sel(1'b1);
    #1;
    chk("reg_pre_edge", 64'(bus.MuxOutQ), 64'h0);
    @(posedge clk); #1;
    chk("reg_post_edge", 64'(bus.MuxOutQ), 64'hABCD);
    chk("reg_sel_q",     64'(bus.sel_q), 64'h1);
    chk("first_toggle",  64'(bus.toggle_cnt), 64'h1);

    // Reset mid-operation.
    @(negedge clk);
    rst = 1'b1; bus.A = 16'hFFFF;
    #1;
    chk("rstprio_mux_pre", 64'(bus.MuxOut), 64'hABCD);
    @(posedge clk); #1;
    chk("rstprio_muxoutq", 64'(bus.MuxOutQ), 64'h0);
    chk("rstprio_sel_q",   64'(bus.sel_q), 64'h0);
    chk("rstprio_cnt",     64'(bus.toggle_cnt), 64'h0);
    chk("rstprio_mux",     64'(bus.MuxOut), 64'hABCD);

    // Toggle counting.
    @(negedge clk);
    rst = 1'b0; set_sel(1'b0);
    @(posedge clk); #1;
    chk("no_toggle_hold", 64'(bus.toggle_cnt), 64'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      set_sel(~bus.sel);
    end
    @(posedge clk); #1;
    chk("toggle6_cnt",  64'(bus.toggle_cnt), 64'd6);
    chk("toggle6_cnt3", 64'(bus3.toggle_cnt), 64'd6);

    // Four more toggles: the 3-bit counter must stop at 7.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      set_sel(~bus.sel);
    end
    @(posedge clk); #1;
    chk("toggle10_cnt", 64'(bus.toggle_cnt), 64'd10);
    chk("sat_cnt3",     64'(bus3.toggle_cnt), 64'd7);

    // Clear wins over a simultaneous toggle.
    @(negedge clk);
    bus.cnt_clr = 1'b1; set_sel(~bus.sel);
    @(posedge clk); #1;
    chk("clr_priority", 64'(bus.toggle_cnt), 64'h0);
    chk("sat_hold3",    64'(bus3.toggle_cnt), 64'd7);
    @(negedge clk);
    bus.cnt_clr = 1'b0; set_sel(~bus.sel);
    @(posedge clk); #1;
    chk("after_clr_inc", 64'(bus.toggle_cnt), 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
